// File: rtl/mem_b_pkg.sv
// Shared constants and types for the port-2 reader of shared memory B.
package mem_b_pkg;

  localparam int MEM_B_AW    = 11;
  localparam int MEM_B_DW    = 256;
  localparam int MEM_B_WORDS = 2048;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  typedef logic [MEM_B_DW-1:0] mem_b_word_t;

endpackage

// File: rtl/mem_b_port2_reader_if.sv
// Output stream of the port-2 reader. A beat transfers on any clock edge where
// m_valid and m_ready are both high; m_data/m_last are held stable while m_valid waits.
interface mem_b_port2_reader_if
  import mem_b_pkg::*;
#(
  parameter int DW = MEM_B_DW
);

  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;
  logic          m_last;

  modport master (
    output m_data,
    output m_valid,
    output m_last,
    input  m_ready
  );

  modport slave (
    input  m_data,
    input  m_valid,
    input  m_last,
    output m_ready
  );

endinterface

// File: rtl/mem_b_rd_fifo.sv
// Small synchronous FIFO for returned read words; a pop frees its slot for a same-cycle push.
module mem_b_rd_fifo #(
  parameter  int WIDTH = 257,
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             do_pop;
  logic             do_push;

  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/mem_b_port2_reader.sv
// Streams a contiguous, wrapping range of 256-bit words from memory B port 2
// into a valid/ready stream, buffering the fixed-latency RAM returns in a FIFO.
module mem_b_port2_reader
  import mem_b_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int AW         = MEM_B_AW,
  parameter int DW         = MEM_B_DW
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [AW-1:0]        base_addr,
  input  logic [AW:0]          length,
  input  logic                 abort,
  output logic                 busy,
  output logic                 done,
  output logic [AW-1:0]        address2,
  output logic                 chipselect2,
  output logic                 write2,
  output logic [DW-1:0]        writedata2,
  output logic [DW/8-1:0]      byteenable2,
  output logic                 clken2,
  input  logic [DW-1:0]        readdata2,
  mem_b_port2_reader_if.master m,
  output state_t               dbg_state
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_t        state;
  state_t        state_nx;
  logic [AW:0]   remaining;
  logic          rd_pend;
  logic          rd_last;
  logic [CW-1:0] fifo_count;
  logic          fifo_empty;
  logic [DW:0]   fifo_head;
  logic [CW:0]   occupancy;
  logic          issue;
  logic          flush;
  logic          pop;

  // Counting the in-flight read against the pre-pop count keeps a slot for every return.
  assign occupancy = {1'b0, fifo_count} + (CW+1)'(rd_pend);
  assign flush     = abort && ((state == RUN) || (state == DRAIN));
  assign issue     = (state == RUN) && (remaining != '0) &&
                     (occupancy < (CW+1)'(FIFO_DEPTH)) && !abort;
  assign pop       = m.m_valid && m.m_ready;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = (length == '0) ? DONE : RUN;
      RUN: begin
        if (abort)                                     state_nx = DONE;
        else if (issue && (remaining == (AW+1)'(1)))   state_nx = DRAIN;
      end
      DRAIN: begin
        if (abort)                       state_nx = DONE;
        else if (!rd_pend && fifo_empty) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      address2  <= '0;
      remaining <= '0;
      rd_pend   <= 1'b0;
      rd_last   <= 1'b0;
    end else begin
      state   <= state_nx;
      rd_pend <= issue;
      if (issue) rd_last <= (remaining == (AW+1)'(1));
      if ((state == IDLE) && start) begin
        address2  <= base_addr;
        remaining <= length;
      end else if (issue) begin
        address2  <= address2 + 1'b1;
        remaining <= remaining - 1'b1;
      end
    end
  end

  // The RAM answers one cycle after chipselect2, so rd_pend marks the cycle readdata2 is live.
  mem_b_rd_fifo #(
    .WIDTH (DW + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (rd_pend),
    .pop   (pop),
    .flush (flush),
    .wdata ({rd_last, readdata2}),
    .count (fifo_count),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

  assign m.m_valid   = !fifo_empty;
  assign m.m_data    = fifo_head[DW-1:0];
  assign m.m_last    = fifo_head[DW] && !fifo_empty;

  assign busy        = (state == RUN) || (state == DRAIN);
  assign done        = (state == DONE);
  assign chipselect2 = issue;
  assign write2      = 1'b0;
  assign writedata2  = '0;
  assign byteenable2 = '1;
  assign clken2      = 1'b1;
  assign dbg_state   = state;

endmodule

// File: tb/tb_mem_b_port2_reader.sv
// Bench for mem_b_port2_reader: a RAM model with one-cycle read latency, a table of
// transfers, hand-written abort/reset/zero-length sequences and random transfers.
module tb_mem_b_port2_reader;
  import mem_b_pkg::*;

  localparam int AW         = MEM_B_AW;
  localparam int DW         = MEM_B_DW;
  localparam int FIFO_DEPTH = 4;
  localparam int W          = DW + 1;

  typedef struct {
    int base;
    int len;
    int rmode;      // 0: ready high, 1: random ready, 2: ready low for 'stall' cycles
    int stall;
    int restart_n;  // sample index after which a stray start is pulsed, -1 for none
    bit abort_ws;   // assert abort together with start
    int exp_first;  // expected sample index of first m_valid
    int exp_beats;
    int exp_end;    // expected address2 after the transfer
  } vec_t;

  // ---------------- clock / reset ----------------
  logic           clk       = 1'b0;
  logic           reset     = 1'b1;
  logic           start     = 1'b0;
  logic [AW-1:0]  base_addr = '0;
  logic [AW:0]    length    = '0;
  logic           abort     = 1'b0;
  logic           busy;
  logic           done;
  logic [AW-1:0]  address2;
  logic           chipselect2;
  logic           write2;
  logic [DW-1:0]  writedata2;
  logic [DW/8-1:0] byteenable2;
  logic           clken2;
  logic [DW-1:0]  readdata2;
  state_t         dbg_state;

  always #5 clk = ~clk;

  mem_b_port2_reader_if #(.DW(DW)) m_if ();

  mem_b_port2_reader #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .AW         (AW),
    .DW         (DW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .base_addr   (base_addr),
    .length      (length),
    .abort       (abort),
    .busy        (busy),
    .done        (done),
    .address2    (address2),
    .chipselect2 (chipselect2),
    .write2      (write2),
    .writedata2  (writedata2),
    .byteenable2 (byteenable2),
    .clken2      (clken2),
    .readdata2   (readdata2),
    .m           (m_if),
    .dbg_state   (dbg_state)
  );

  // ---------------- RAM model: registered address, unregistered output ----------------
  mem_b_word_t   ram [MEM_B_WORDS];
  logic [AW-1:0] ram_addr_q = '0;
  logic          ram_vld_q  = 1'b0;
  mem_b_word_t   junk       = '0;

  always @(posedge clk) begin
    ram_vld_q <= chipselect2;
    if (chipselect2) ram_addr_q <= address2;
    junk <= {8{$urandom}};
  end

  // Outside the valid return cycle the data bus carries garbage.
  assign readdata2 = ram_vld_q ? ram[ram_addr_q] : junk;

  // ---------------- scoreboard ----------------
  int         total_cnt = 0;
  int         pass_cnt  = 0;
  int         cs_cnt    = 0;
  int         done_cnt  = 0;
  int         beat_cnt  = 0;
  bit         busy_seen = 1'b0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (chipselect2) cs_cnt++;
      if (done) done_cnt++;
      if (busy) busy_seen = 1'b1;
      if (m_if.m_valid && m_if.m_ready) begin
        beat_cnt++;
        check("beat_expected", W'(exp_q.size() != 0), W'(1));
        if (exp_q.size() != 0) check("beat_data_last", {m_if.m_last, m_if.m_data}, exp_q.pop_front());
      end
    end
  end

  // Reference: a transfer yields words base, base+1, ... modulo the RAM size, last flag on the final one.
  task automatic model_xfer(input int base, input int len);
    for (int k = 0; k < len; k++)
      exp_q.push_back({(k == len - 1), ram[(base + k) % MEM_B_WORDS]});
  endtask

  // ---------------- drivers ----------------
  task automatic reset_counters();
    cs_cnt    = 0;
    done_cnt  = 0;
    beat_cnt  = 0;
    busy_seen = 1'b0;
  endtask

  task automatic start_xfer(input int base, input int len, input bit with_abort);
    base_addr = AW'(base);
    length    = (AW+1)'(len);
    start     = 1'b1;
    abort     = with_abort;
    @(posedge clk); #1;
    start     = 1'b0;
    abort     = 1'b0;
    base_addr = AW'($urandom);
    length    = (AW+1)'($urandom);
  endtask

  // Sample index n is the negedge following the n-th posedge after the edge that took start.
  task automatic run_xfer(input vec_t v);
    int first_v;
    int last_n;
    int done_n;
    first_v = -1;
    last_n  = -1;
    done_n  = -1;
    reset_counters();
    model_xfer(v.base, v.len);
    m_if.m_ready = (v.rmode == 0);
    start_xfer(v.base, v.len, v.abort_ws);
    for (int n = 0; (n < v.len * 4 + 50) && (done_n < 0); n++) begin
      @(negedge clk);
      if (m_if.m_valid && first_v < 0) first_v = n;
      if (m_if.m_valid && m_if.m_ready && m_if.m_last) last_n = n;
      if (done) done_n = n;
      if (v.rmode == 2 && n == v.stall - 1) begin
        check("stall_issue_count", W'(cs_cnt), W'(FIFO_DEPTH));
        check("stall_cs_low", W'(chipselect2), W'(0));
      end
      @(posedge clk); #1;
      case (v.rmode)
        0:       m_if.m_ready = 1'b1;
        1:       m_if.m_ready = 1'($urandom_range(0, 1));
        default: m_if.m_ready = (n + 1 >= v.stall);
      endcase
      start = (n == v.restart_n);
      if (start) begin
        base_addr = AW'(10);
        length    = (AW+1)'(3);
      end
    end
    start = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("done_seen", W'(done_n >= 0), W'(1));
    check("first_valid_latency", W'(first_v), W'(v.exp_first));
    check("done_after_last", W'(done_n), W'(last_n + 2));
    check("beat_count", W'(beat_cnt), W'(v.exp_beats));
    check("issue_count", W'(cs_cnt), W'(v.exp_beats));
    check("done_pulses", W'(done_cnt), W'(1));
    check("busy_seen", W'(busy_seen), W'(1));
    check("queue_drained", W'(exp_q.size()), W'(0));
    check("end_address", W'(address2), W'(v.exp_end));
    check("idle_after", W'(dbg_state), W'(IDLE));
    exp_q.delete();
    m_if.m_ready = 1'b1;
  endtask

  // ---------------- test ----------------
  initial begin
    vec_t tbl[9];
    vec_t rv;
    int   nb;
    int   dn;
    bit   any_valid;

    tbl[0] = '{0,    4,    0, 0,  -1, 1'b0, 2, 4,    4};
    tbl[1] = '{2046, 4,    0, 0,  -1, 1'b0, 2, 4,    2};
    tbl[2] = '{8,    8,    2, 10, -1, 1'b0, 2, 8,    16};
    tbl[3] = '{700,  6,    0, 0,  3,  1'b0, 2, 6,    706};
    tbl[4] = '{20,   2,    0, 0,  -1, 1'b1, 2, 2,    22};
    tbl[5] = '{1000, 16,   1, 0,  -1, 1'b0, 2, 16,   1016};
    tbl[6] = '{2040, 20,   1, 0,  -1, 1'b0, 2, 20,   12};
    tbl[7] = '{0,    2048, 0, 0,  -1, 1'b0, 2, 2048, 0};
    tbl[8] = '{1234, 2048, 1, 0,  -1, 1'b0, 2, 2048, 1234};

    for (int i = 0; i < MEM_B_WORDS; i++) ram[i] = {8{i}};
    m_if.m_ready = 1'b1;

    // reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", W'(busy), W'(0));
    check("rst_done", W'(done), W'(0));
    check("rst_cs", W'(chipselect2), W'(0));
    check("rst_valid", W'(m_if.m_valid), W'(0));
    check("rst_last", W'(m_if.m_last), W'(0));
    check("rst_addr", W'(address2), W'(0));
    check("rst_state", W'(dbg_state), W'(IDLE));
    check("const_write2", W'(write2), W'(0));
    check("const_clken2", W'(clken2), W'(1));
    check("const_byteen", W'(byteenable2), W'({(DW/8){1'b1}}));
    check("const_wdata", W'(writedata2), W'(0));
    @(posedge clk); #1;
    reset = 1'b0;

    // zero-length transfer
    reset_counters();
    dn = -1;
    start_xfer(5, 0, 1'b0);
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      if (done && dn < 0) dn = n;
    end
    #1;
    check("len0_done_seen", W'(dn >= 0), W'(1));
    check("len0_done_pulses", W'(done_cnt), W'(1));
    check("len0_no_reads", W'(cs_cnt), W'(0));
    check("len0_busy_never", W'(busy_seen), W'(0));
    @(posedge clk); #1;

    // table of transfers
    for (int i = 0; i < 9; i++) run_xfer(tbl[i]);

    // abort after five accepted beats
    reset_counters();
    model_xfer(300, 16);
    m_if.m_ready = 1'b1;
    start_xfer(300, 16, 1'b0);
    nb = 0;
    for (int n = 0; (n < 60) && (nb < 5); n++) begin
      @(negedge clk);
      if (m_if.m_valid && m_if.m_ready) nb++;
      @(posedge clk); #1;
    end
    abort        = 1'b1;
    m_if.m_ready = 1'b0;
    @(posedge clk); #1;
    abort        = 1'b0;
    m_if.m_ready = 1'b1;
    @(negedge clk);
    check("abort_done", W'(done), W'(1));
    check("abort_valid_low", W'(m_if.m_valid), W'(0));
    check("abort_busy_low", W'(busy), W'(0));
    any_valid = 1'b0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      if (m_if.m_valid) any_valid = 1'b1;
    end
    #1;
    check("abort_valid_stays_low", W'(any_valid), W'(0));
    check("abort_beats", W'(beat_cnt), W'(5));
    check("abort_done_pulses", W'(done_cnt), W'(1));
    check("abort_leftover", W'(exp_q.size()), W'(11));
    exp_q.delete();
    @(posedge clk); #1;
    rv = '{100, 1, 0, 0, -1, 1'b0, 2, 1, 101};
    run_xfer(rv);

    // reset in the middle of a transfer
    reset_counters();
    model_xfer(50, 16);
    start_xfer(50, 16, 1'b0);
    repeat (6) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_busy", W'(busy), W'(0));
    check("midrst_done", W'(done), W'(0));
    check("midrst_cs", W'(chipselect2), W'(0));
    check("midrst_valid", W'(m_if.m_valid), W'(0));
    check("midrst_last", W'(m_if.m_last), W'(0));
    check("midrst_addr", W'(address2), W'(0));
    check("midrst_state", W'(dbg_state), W'(IDLE));
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();
    reset_counters();
    repeat (5) @(negedge clk);
    #1;
    check("midrst_no_done", W'(done_cnt), W'(0));
    check("midrst_idle", W'(busy_seen), W'(0));
    @(posedge clk); #1;

    // random transfers with random backpressure
    for (int r = 0; r < 8; r++) begin
      rv.base      = int'($urandom_range(0, MEM_B_WORDS - 1));
      rv.len       = int'($urandom_range(1, 40));
      rv.rmode     = 1;
      rv.stall     = 0;
      rv.restart_n = -1;
      rv.abort_ws  = 1'b0;
      rv.exp_first = 2;
      rv.exp_beats = rv.len;
      rv.exp_end   = (rv.base + rv.len) % MEM_B_WORDS;
      run_xfer(rv);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
